// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode/funct encodings, ALU ops, decoded control word, memory FSM states.
// Latency: n/a (types and a pure combinational decode function).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38,
        OP_HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2a,
        F_SLTU = 6'h2b
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic {
        IDLE = 1'b0,
        DREQ = 1'b1
    } memfsm_t;

    typedef struct packed {
        aluop_t alu_op;
        logic   RegWrite;
        logic   MemtoReg;
        logic   Alusrc;
        logic   RegDest;
        logic   Shamt;
        logic   Ext;
        logic   LUI;
        logic   ImmtoReg;
        logic   beq;
        logic   bne;
        logic   Jump;
        logic   Jr;
        logic   Link;
    } ctrl_t;

    // Opcodes that the memory FSM treats specially.
    localparam opcode_t LL_OPCODE   = OP_LL;
    localparam opcode_t SC_OPCODE   = OP_SC;
    localparam opcode_t HALT_OPCODE = OP_HALT;

    // Datapath control decode. With LL/SC disabled, SC behaves as a plain SW
    // (no rt write-back); LL always decodes like LW.
    function automatic ctrl_t decode(opcode_t op, funct_t fn, logic llsc);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.RegWrite = 1'b1;
                c.RegDest  = 1'b1;
                case (fn)
                    F_SLL:         begin c.alu_op = ALU_SLL; c.Shamt = 1'b1; end
                    F_SRL:         begin c.alu_op = ALU_SRL; c.Shamt = 1'b1; end
                    F_JR:          begin c.Jr = 1'b1; c.RegWrite = 1'b0; end
                    F_ADD, F_ADDU: c.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: c.alu_op = ALU_SUB;
                    F_AND:         c.alu_op = ALU_AND;
                    F_OR:          c.alu_op = ALU_OR;
                    F_XOR:         c.alu_op = ALU_XOR;
                    F_NOR:         c.alu_op = ALU_NOR;
                    F_SLT:         c.alu_op = ALU_SLT;
                    F_SLTU:        c.alu_op = ALU_SLTU;
                    default:       c.RegWrite = 1'b0;
                endcase
            end
            OP_J:     c.Jump = 1'b1;
            OP_JAL:   begin c.Jump = 1'b1; c.Link = 1'b1; c.RegWrite = 1'b1; end
            OP_BEQ:   begin c.beq = 1'b1; c.alu_op = ALU_SUB; end
            OP_BNE:   begin c.bne = 1'b1; c.alu_op = ALU_SUB; end
            OP_ADDI, OP_ADDIU: begin
                c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.Ext = 1'b1; c.alu_op = ALU_ADD;
            end
            OP_SLTI:  begin c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.Ext = 1'b1; c.alu_op = ALU_SLT; end
            OP_SLTIU: begin c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.Ext = 1'b1; c.alu_op = ALU_SLTU; end
            OP_ANDI:  begin c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.alu_op = ALU_AND; end
            OP_ORI:   begin c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.alu_op = ALU_OR; end
            OP_XORI:  begin c.RegWrite = 1'b1; c.Alusrc = 1'b1; c.alu_op = ALU_XOR; end
            OP_LUI:   begin c.RegWrite = 1'b1; c.LUI = 1'b1; end
            OP_LW, OP_LL: begin
                c.RegWrite = 1'b1; c.MemtoReg = 1'b1; c.Alusrc = 1'b1; c.Ext = 1'b1;
                c.alu_op = ALU_ADD;
            end
            OP_SW:    begin c.Alusrc = 1'b1; c.Ext = 1'b1; c.alu_op = ALU_ADD; end
            OP_SC: begin
                c.Alusrc = 1'b1; c.Ext = 1'b1; c.alu_op = ALU_ADD;
                // rt receives the SC success flag, so SC writes back whether or not it passes.
                if (llsc) begin
                    c.RegWrite = 1'b1;
                    c.ImmtoReg = 1'b1;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ll_sc_link.sv
// Load-linked reservation tracker: one link address plus valid bit.
// Latency: updates on the clock edge after an LL/store completion or snoop.
// Backpressure: none; consumes completion and snoop strobes every cycle.
module ll_sc_link #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ll_done,
    input  logic              i_wr_done,
    input  logic [DATA_W-1:0] i_addr,
    input  logic              i_snoop_inv,
    input  logic [DATA_W-1:0] i_snoop_addr,
    output logic              o_link_valid,
    output logic [DATA_W-1:0] o_link_addr
);

    logic              r_link_valid;
    logic [DATA_W-1:0] r_link_addr;
    logic [DATA_W-1:0] w_cmp_addr;
    logic              w_kill;
    logic              w_valid_nxt;

    // A snoop landing in the same cycle as an LL completion is checked against
    // the address being linked, so the invalidate beats the new reservation.
    assign w_cmp_addr  = i_ll_done ? i_addr : r_link_addr;
    assign w_kill      = (i_snoop_inv && (i_snoop_addr == w_cmp_addr)) ||
                         (i_wr_done && (i_addr == r_link_addr));
    assign w_valid_nxt = (r_link_valid | i_ll_done) & ~w_kill;

    // Reservation register: set by LL completion, cleared by snoops or stores to the link.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else begin
            if (i_ll_done) begin
                r_link_addr <= i_addr;
            end
            r_link_valid <= w_valid_nxt;
        end
    end

    assign o_link_valid = r_link_valid;
    assign o_link_addr  = r_link_addr;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control: instruction decode, data-memory request FSM, LL/SC, halt and watchdog.
// Latency: decode and request issue combinational; FSM/flags update on the next edge.
// Backpressure: PCWait stalls fetch while a data request waits for dhit.
module pipe_control_unit
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LLSC_EN  = 1,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [DATA_W-1:0] daddr,
    input  logic              snoop_inv,
    input  logic [DATA_W-1:0] snoop_addr,
    output ctrl_t             ctrl,
    output logic              dRead,
    output logic              dWrite,
    output logic              PCWait,
    output logic              sc_result,
    output logic              halt,
    output logic              mem_timeout
);

    localparam int               CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic             LLSC    = (LLSC_EN != 0);

    memfsm_t           r_state;
    logic              r_rd, r_wr, r_ll, r_sc;
    logic [DATA_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_halt, r_timeout;

    opcode_t           w_op;
    funct_t            w_fn;
    logic              w_unused;
    logic              w_is_lw, w_is_sw, w_is_ll, w_is_sc, w_sc_pass, w_memop;
    logic              w_rd, w_wr, w_ll, w_sc, w_done;
    logic [DATA_W-1:0] w_addr;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_link_valid;
    logic [DATA_W-1:0] w_link_addr;

    assign w_op     = opcode_t'(instr[31:26]);
    assign w_fn     = funct_t'(instr[5:0]);
    assign w_unused = ^instr[25:6];

    // Without LL/SC, LL is an ordinary load and SC an ordinary store.
    assign w_is_lw   = (w_op == OP_LW) || (!LLSC && (w_op == LL_OPCODE));
    assign w_is_sw   = (w_op == OP_SW) || (!LLSC && (w_op == SC_OPCODE));
    assign w_is_ll   = LLSC && (w_op == LL_OPCODE);
    assign w_is_sc   = LLSC && (w_op == SC_OPCODE);
    assign w_sc_pass = w_is_sc && w_link_valid && (daddr == w_link_addr);
    assign w_memop   = ihit && (w_is_lw || w_is_sw || w_is_ll || w_sc_pass) && !r_halt;

    // Request select: issue straight from decode in IDLE, replay latched request in DREQ.
    always_comb begin
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_ll   = 1'b0;
        w_sc   = 1'b0;
        w_addr = daddr;
        if (r_state == DREQ) begin
            w_rd   = r_rd;
            w_wr   = r_wr;
            w_ll   = r_ll;
            w_sc   = r_sc;
            w_addr = r_addr;
        end else if (w_memop) begin
            w_rd = w_is_lw | w_is_ll;
            w_wr = w_is_sw | w_sc_pass;
            w_ll = w_is_ll;
            w_sc = w_is_sc;
        end
        if (RST) begin
            w_rd = 1'b0;
            w_wr = 1'b0;
            w_ll = 1'b0;
            w_sc = 1'b0;
        end
    end

    assign w_done    = (w_rd | w_wr) & dhit;
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Memory FSM with watchdog and sticky halt/timeout flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_ll      <= 1'b0;
            r_sc      <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_halt    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (ihit && (w_op == HALT_OPCODE)) begin
                r_halt <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_memop && !dhit) begin
                        r_state <= DREQ;
                        r_rd    <= w_rd;
                        r_wr    <= w_wr;
                        r_ll    <= w_ll;
                        r_sc    <= w_sc;
                        r_addr  <= daddr;
                    end
                end
                DREQ: begin
                    r_cnt <= w_cnt_nxt;
                    // Timeout only flags the stall; the request keeps waiting for dhit.
                    if (w_cnt_nxt == CNT_MAX) begin
                        r_timeout <= 1'b1;
                    end
                    if (dhit) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (LLSC_EN != 0) begin : g_link
            ll_sc_link #(.DATA_W(DATA_W)) u_link (
                .i_clk        (CLK),
                .i_rst        (RST),
                .i_ll_done    (w_ll & w_done),
                .i_wr_done    (w_wr & w_done),
                .i_addr       (w_addr),
                .i_snoop_inv  (snoop_inv),
                .i_snoop_addr (snoop_addr),
                .o_link_valid (w_link_valid),
                .o_link_addr  (w_link_addr)
            );
        end else begin : g_no_link
            assign w_link_valid = 1'b0;
            assign w_link_addr  = '0;
        end
    endgenerate

    assign ctrl        = (ihit && !RST) ? decode(w_op, w_fn, LLSC) : '0;
    assign dRead       = w_rd;
    assign dWrite      = w_wr;
    assign PCWait      = (w_rd | w_wr) & ~dhit;
    assign sc_result   = w_sc & dhit;
    assign halt        = r_halt;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit (watchdog limit set to 4 cycles).
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns later.
// Backpressure: dhit is scripted per cycle to create zero-wait and multi-cycle accesses.
module tb_pipe_control_unit;
    import cpu_types_pkg::*;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST, ihit, dhit, snoop_inv;
    logic [DW-1:0] instr, daddr, snoop_addr;
    ctrl_t         ctrl;
    logic          dRead, dWrite, PCWait, sc_result, halt, mem_timeout;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 CLK = ~CLK;

    pipe_control_unit #(.DATA_W(DW), .LLSC_EN(1), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .daddr(daddr),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .ctrl(ctrl), .dRead(dRead),
        .dWrite(dWrite), .PCWait(PCWait), .sc_result(sc_result), .halt(halt),
        .mem_timeout(mem_timeout)
    );

    function automatic logic [DW-1:0] mk(opcode_t op);
        return {op, 26'd0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit = 1'b1; instr = mk(OP_LW); daddr = 32'h100; dhit = 1'b0;
        #2;
        n_total++;
        if ({dRead, dWrite, PCWait, sc_result, halt, mem_timeout} !== 6'b0)
            $display("FAIL reset_outs got=%b want=000000", {dRead, dWrite, PCWait, sc_result, halt, mem_timeout});
        else n_pass++;
        n_total++;
        if (ctrl !== '0) $display("FAIL reset_ctrl got=%h want=0", ctrl); else n_pass++;
        tick();
        RST = 1'b0; ihit = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        ctrl_t e;
        ihit = 1'b0; instr = mk(OP_LW); dhit = 1'b0; #2;
        n_total++;
        if (ctrl !== '0) $display("FAIL dec_no_ihit got=%h want=0", ctrl); else n_pass++;
        tick();
        ihit = 1'b1; instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; #2;
        e = '0; e.alu_op = ALU_ADD; e.RegWrite = 1'b1; e.RegDest = 1'b1;
        n_total++;
        if (ctrl !== e) $display("FAIL dec_add got=%h want=%h", ctrl, e); else n_pass++;
        tick();
        instr = mk(OP_BEQ); #2;
        e = '0; e.alu_op = ALU_SUB; e.beq = 1'b1;
        n_total++;
        if (ctrl !== e) $display("FAIL dec_beq got=%h want=%h", ctrl, e); else n_pass++;
        tick();
        instr = mk(OP_JAL); #2;
        e = '0; e.Jump = 1'b1; e.Link = 1'b1; e.RegWrite = 1'b1;
        n_total++;
        if (ctrl !== e) $display("FAIL dec_jal got=%h want=%h", ctrl, e); else n_pass++;
        tick();
        instr = mk(OP_ORI); #2;
        e = '0; e.alu_op = ALU_OR; e.RegWrite = 1'b1; e.Alusrc = 1'b1;
        n_total++;
        if (ctrl !== e) $display("FAIL dec_ori got=%h want=%h", ctrl, e); else n_pass++;
        tick();
        instr = mk(OP_LUI); #2;
        e = '0; e.LUI = 1'b1; e.RegWrite = 1'b1;
        n_total++;
        if (ctrl !== e) $display("FAIL dec_lui got=%h want=%h", ctrl, e); else n_pass++;
        n_total++;
        if ({dRead, dWrite, PCWait} !== 3'b0) $display("FAIL dec_no_mem got=%b want=000", {dRead, dWrite, PCWait}); else n_pass++;
        tick();
        ihit = 1'b0;
    endtask

    task automatic test_lw_miss();
        int nr = 0;
        int nw = 0;
        ctrl_t e;
        e = '0; e.alu_op = ALU_ADD; e.RegWrite = 1'b1; e.MemtoReg = 1'b1; e.Alusrc = 1'b1; e.Ext = 1'b1;
        daddr = 32'h100; instr = mk(OP_LW);
        for (int c = 0; c < 5; c++) begin
            ihit = (c < 3); dhit = (c == 2);
            #2;
            if (dRead) nr++;
            if (PCWait) nw++;
            if (c == 0) begin
                n_total++;
                if (ctrl !== e) $display("FAIL lw_ctrl got=%h want=%h", ctrl, e); else n_pass++;
            end
            tick();
        end
        n_total++;
        if (nr !== 3) $display("FAIL lw_dread_cycles got=%0d want=3", nr); else n_pass++;
        n_total++;
        if (nw !== 2) $display("FAIL lw_pcwait_cycles got=%0d want=2", nw); else n_pass++;
        // Back in IDLE: a zero-wait load issues immediately without stalling.
        ihit = 1'b1; dhit = 1'b1; #2;
        n_total++;
        if ({dRead, PCWait} !== 2'b10) $display("FAIL lw_idle_hit got=%b want=10", {dRead, PCWait}); else n_pass++;
        tick();
        ihit = 1'b0; dhit = 1'b0;
    endtask

    task automatic test_sw_hit();
        int nw = 0;
        int np = 0;
        instr = mk(OP_SW); daddr = 32'h180;
        for (int c = 0; c < 3; c++) begin
            ihit = (c == 0); dhit = (c == 0);
            #2;
            if (dWrite) nw++;
            if (PCWait) np++;
            tick();
        end
        n_total++;
        if (nw !== 1) $display("FAIL sw_dwrite_cycles got=%0d want=1", nw); else n_pass++;
        n_total++;
        if (np !== 0) $display("FAIL sw_pcwait_cycles got=%0d want=0", np); else n_pass++;
    endtask

    task automatic test_ll_sc();
        ihit = 1'b1; instr = mk(OP_LL); daddr = 32'h200; dhit = 1'b1; #2;
        n_total++;
        if ({dRead, dWrite} !== 2'b10) $display("FAIL ll_issue got=%b want=10", {dRead, dWrite}); else n_pass++;
        tick();
        instr = mk(OP_SC); dhit = 1'b0; #2;
        n_total++;
        if ({dWrite, PCWait, sc_result} !== 3'b110) $display("FAIL sc_wait got=%b want=110", {dWrite, PCWait, sc_result}); else n_pass++;
        tick();
        dhit = 1'b1; #2;
        n_total++;
        if ({dWrite, PCWait, sc_result} !== 3'b101) $display("FAIL sc_done got=%b want=101", {dWrite, PCWait, sc_result}); else n_pass++;
        tick();
        // Link consumed by the successful SC: a repeat SC must fail.
        dhit = 1'b0; #2;
        n_total++;
        if ({dRead, dWrite, PCWait, sc_result} !== 4'b0) $display("FAIL sc_repeat got=%b want=0000", {dRead, dWrite, PCWait, sc_result}); else n_pass++;
        n_total++;
        if (ctrl.RegWrite !== 1'b1) $display("FAIL sc_fail_regwrite got=%b want=1", ctrl.RegWrite); else n_pass++;
        tick();
        ihit = 1'b0;
    endtask

    task automatic test_snoop();
        ihit = 1'b1; instr = mk(OP_LL); daddr = 32'h200; dhit = 1'b1;
        snoop_inv = 1'b1; snoop_addr = 32'h200;
        tick();
        snoop_inv = 1'b0; instr = mk(OP_SC); #2;
        n_total++;
        if ({dWrite, PCWait, sc_result} !== 3'b0) $display("FAIL snoop_ll_race got=%b want=000", {dWrite, PCWait, sc_result}); else n_pass++;
        tick();
        instr = mk(OP_LL); daddr = 32'h300; snoop_inv = 1'b1; snoop_addr = 32'h304;
        tick();
        snoop_inv = 1'b0; instr = mk(OP_SC); daddr = 32'h204; #2;
        n_total++;
        if (dWrite !== 1'b0) $display("FAIL sc_wrong_addr got=%b want=0", dWrite); else n_pass++;
        tick();
        daddr = 32'h300; #2;
        n_total++;
        if ({dWrite, sc_result} !== 2'b11) $display("FAIL sc_other_snoop got=%b want=11", {dWrite, sc_result}); else n_pass++;
        tick();
        instr = mk(OP_LL); daddr = 32'h400;
        tick();
        instr = mk(OP_SW); #2;
        n_total++;
        if (dWrite !== 1'b1) $display("FAIL sw_to_link got=%b want=1", dWrite); else n_pass++;
        tick();
        instr = mk(OP_SC); #2;
        n_total++;
        if ({dWrite, sc_result} !== 2'b00) $display("FAIL sc_after_sw got=%b want=00", {dWrite, sc_result}); else n_pass++;
        tick();
        instr = mk(OP_LL); daddr = 32'h500;
        tick();
        ihit = 1'b0; snoop_inv = 1'b1; snoop_addr = 32'h500;
        tick();
        snoop_inv = 1'b0; ihit = 1'b1; instr = mk(OP_SC); #2;
        n_total++;
        if ({dWrite, sc_result} !== 2'b00) $display("FAIL sc_after_snoop got=%b want=00", {dWrite, sc_result}); else n_pass++;
        tick();
        ihit = 1'b0; dhit = 1'b0;
    endtask

    task automatic test_timeout();
        logic [1:0] want_rp;
        instr = mk(OP_LW); daddr = 32'h600;
        for (int c = 0; c < 8; c++) begin
            ihit = (c <= 6); dhit = (c == 6);
            want_rp = (c <= 5) ? 2'b11 : ((c == 6) ? 2'b10 : 2'b00);
            #2;
            n_total++;
            if ({dRead, PCWait} !== want_rp) $display("FAIL wd_req c=%0d got=%b want=%b", c, {dRead, PCWait}, want_rp); else n_pass++;
            n_total++;
            if (mem_timeout !== (c >= 5)) $display("FAIL wd_flag c=%0d got=%b want=%b", c, mem_timeout, (c >= 5)); else n_pass++;
            tick();
        end
        ihit = 1'b0; dhit = 1'b0;
    endtask

    task automatic test_rst_halt();
        ihit = 1'b1; instr = mk(OP_LW); daddr = 32'h100; dhit = 1'b0;
        tick();
        #2;
        n_total++;
        if ({dRead, PCWait} !== 2'b11) $display("FAIL rst_pre_dreq got=%b want=11", {dRead, PCWait}); else n_pass++;
        RST = 1'b1; #1;
        n_total++;
        if ({dRead, PCWait, mem_timeout} !== 3'b0) $display("FAIL rst_mid_dreq got=%b want=000", {dRead, PCWait, mem_timeout}); else n_pass++;
        tick();
        RST = 1'b0; ihit = 1'b0; dhit = 1'b1; #2;
        n_total++;
        if ({dRead, dWrite, PCWait, halt} !== 4'b0) $display("FAIL rst_dropped got=%b want=0000", {dRead, dWrite, PCWait, halt}); else n_pass++;
        tick();
        ihit = 1'b1; instr = mk(OP_HALT); dhit = 1'b0;
        tick();
        n_total++;
        if (halt !== 1'b1) $display("FAIL halt_set got=%b want=1", halt); else n_pass++;
        instr = mk(OP_LW); #2;
        n_total++;
        if ({dRead, PCWait} !== 2'b00) $display("FAIL halt_blocks_lw got=%b want=00", {dRead, PCWait}); else n_pass++;
        tick();
        ihit = 1'b0;
        tick();
        n_total++;
        if (halt !== 1'b1) $display("FAIL halt_sticky got=%b want=1", halt); else n_pass++;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; instr = '0; daddr = '0;
        snoop_inv = 1'b0; snoop_addr = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_decode();
        test_lw_miss();
        test_sw_hit();
        test_ll_sc();
        test_snoop();
        test_timeout();
        test_rst_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the instruction, address and link register.
REQ-002 SHALL have parameter LLSC_EN, default 1, meaning LL/SC support is on; when 0, LL decodes as LW and SC as SW.
REQ-003 SHALL have parameter MAX_WAIT, default 255, meaning the data-stall watchdog limit in cycles.
REQ-004 SHALL have one clock, CLK, with asynchronous active-high reset RST.
REQ-005 CLK  in  1  system clock.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 instr  in  DATA_W  fetched instruction; opcode and funct fields use the shared types.
REQ-008 ihit  in  1  instruction valid this cycle.
REQ-009 dhit  in  1  data access complete this cycle.
REQ-010 daddr  in  DATA_W  effective data address of the current instruction.
REQ-011 snoop_inv  in  1  external invalidate strobe.
REQ-012 snoop_addr  in  DATA_W  invalidate address.
REQ-013 ctrl  out  ctrl_t  decoded datapath flags: alu_op, RegWrite, MemtoReg, Alusrc, RegDest, Shamt, Ext, LUI, ImmtoReg, beq, bne, Jump, Jr, Link.
REQ-014 dRead  out  1  data read request.
REQ-015 dWrite  out  1  data write request.
REQ-016 PCWait  out  1  hold PC and fetch.
REQ-017 sc_result  out  1  value written to rt by SC (1 = success).
REQ-018 halt  out  1  sticky halt flag.
REQ-019 mem_timeout  out  1  sticky watchdog flag.

Function
REQ-020 ctrl SHALL be a purely combinational decode of instr, valid only when ihit=1, and SHALL be all-zero otherwise.
REQ-021 FSM states SHALL be IDLE and DREQ.
- memop = ihit & (LW|SW|LL|SC-pass) & !halt
- SC-pass = SC & link_valid & (daddr==link_addr)
REQ-022 In IDLE with memop, dRead (loads) or dWrite (stores) SHALL assert in the same cycle.
- dhit=1 that cycle: stay IDLE
- dhit=0: go to DREQ
REQ-023 In DREQ, the request SHALL be held stable until dhit=1, then the FSM SHALL return to IDLE.
REQ-024 PCWait SHALL equal (dRead|dWrite) & !dhit.
- Zero-wait hit: no stall
- N-cycle miss: exactly N stall cycles
REQ-025 LL completion (dhit) SHALL set link_valid=1 and link_addr=daddr.
REQ-026 SC-pass SHALL issue dWrite, set sc_result=1 and clear link_valid on dhit.
REQ-027 SC failing the link check SHALL issue no request, no stall, set sc_result=0 and RegWrite=1.
REQ-028 link_valid SHALL clear on:
- snoop_inv with snoop_addr==link_addr
- completed SW or SC to link_addr
REQ-029 If LL completion and a matching invalidate occur in the same cycle, the invalidate SHALL win, leaving link_valid=0.
REQ-030 The watchdog counter SHALL increment each DREQ cycle, clear in IDLE, and saturate at MAX_WAIT.
REQ-031 Reaching MAX_WAIT SHALL set mem_timeout sticky; the FSM SHALL keep waiting.
REQ-032 HALT with ihit SHALL set halt sticky.
- Once halted, no new requests issue
- A DREQ in flight completes normally

Reset
REQ-033 RST SHALL asynchronously force FSM=IDLE, link_valid=0, link_addr=0, counter=0, halt=0, mem_timeout=0.
REQ-034 Under RST, all outputs SHALL be 0, including dRead, dWrite, PCWait and sc_result.
REQ-035 RST asserted mid-DREQ SHALL drop the request immediately, with no completion side effects.

Structure
REQ-036 cpu_types_pkg SHALL hold the shared types and constants:
- opcode_t, funct_t, aluop_t
- new ctrl_t struct and memfsm_t enum
- LL/SC/HALT opcode constants
REQ-037 Link tracking (REQ-025, REQ-026, REQ-028, REQ-029) SHALL be the sub-module ll_sc_link, instantiated only when LLSC_EN=1.

Verification
REQ-038 LW at 0x100, dhit after 3 cycles -> dRead high 3 cycles, PCWait high 2 cycles, then FSM IDLE.
REQ-039 SW with dhit in the same cycle -> dWrite for 1 cycle, PCWait never high.
REQ-040 LL 0x200 then SC 0x200 -> sc_result=1, dWrite issued, link_valid=0 afterwards.
REQ-041 LL 0x200, snoop_inv 0x200 in the LL completion cycle, then SC 0x200 -> sc_result=0, no dWrite, PCWait=0.
REQ-042 MAX_WAIT=4, LW with dhit withheld 6 cycles -> mem_timeout rises at cycle 4, request held, PCWait stays high.
REQ-043 RST pulse during DREQ -> dRead=0 and PCWait=0 immediately; HALT then sets halt=1 and blocks a following LW.
